udp_sf_frame_fifo: RTL and testbench

//  Store-and-forward UDP payload FIFO between the UDP/MAC AXI-stream ingress and moldudp64.

---
 rtl/hft_pkg.sv | 18 +
 rtl/sf_fifo_ram.sv | 35 +++
 rtl/udp_sf_frame_fifo.sv | 190 +++++++++++++++++++
 tb/tb_udp_sf_frame_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// ----------------------------------------------------------------------------
// hft_pkg
//   Shared types and default widths for the UDP store-and-forward frame FIFO.
//   sf_state_e    : ingress state (idle / storing a frame / discarding a frame)
//   HFT_AXI_*_DEF : default AXI-stream data and keep widths
// ----------------------------------------------------------------------------
package hft_pkg;

    localparam int unsigned HFT_AXI_DATA_W_DEF = 64;
    localparam int unsigned HFT_AXI_KEEP_W_DEF = HFT_AXI_DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DROP  = 2'd2
    } sf_state_e;

endpackage

// File: rtl/sf_fifo_ram.sv
// ----------------------------------------------------------------------------
// sf_fifo_ram
//   Simple dual-port buffer: one synchronous write port, one asynchronous
//   (combinational) read port. Contents are not reset.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address
//   o_rd_data : read data (combinational from i_rd_addr)
// ----------------------------------------------------------------------------
module sf_fifo_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WIDTH  = 73
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/udp_sf_frame_fifo.sv
// ----------------------------------------------------------------------------
// udp_sf_frame_fifo
//   Store-and-forward frame FIFO between the UDP/MAC AXI-stream ingress and
//   moldudp64. A frame becomes visible to the egress only after its tlast
//   beat arrives error-free and fully stored; otherwise it is discarded whole.
//   Ports:
//     clk, reset                 : clock, asynchronous active-high reset
//     udp_axis_t*_i / tready_o   : ingress stream (always ready out of reset)
//     mold_axis_t*_o / tready_i  : egress stream towards moldudp64
//     frame_drop_o               : one-cycle pulse per discarded frame
//     drop_cnt_o                 : saturating count of discarded frames
// ----------------------------------------------------------------------------
module udp_sf_frame_fifo
    import hft_pkg::*;
#(
    parameter int unsigned AXI_DATA_W = HFT_AXI_DATA_W_DEF,
    parameter int unsigned AXI_KEEP_W = HFT_AXI_KEEP_W_DEF,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  udp_axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] udp_axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] udp_axis_tdata_i,
    input  logic                  udp_axis_tlast_i,
    input  logic                  udp_axis_tuser_i,
    output logic                  udp_axis_tready_o,
    output logic                  mold_axis_tvalid_o,
    output logic [AXI_KEEP_W-1:0] mold_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] mold_axis_tdata_o,
    output logic                  mold_axis_tlast_o,
    output logic                  mold_axis_tuser_o,
    input  logic                  mold_axis_tready_i,
    output logic                  frame_drop_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned RAM_W = AXI_DATA_W + AXI_KEEP_W + 1;
    localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
    localparam logic [DROP_CNT_W-1:0] CNT_ONE = DROP_CNT_W'(1);

    sf_state_e r_state, w_state_nxt;

    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_commit_ptr, w_commit_nxt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_bad, w_bad_nxt;
    logic             w_wr_en;
    logic             w_drop;
    logic             w_full;
    logic             w_bad_frame;
    logic             w_load;
    logic [RAM_W-1:0] w_wr_word;
    logic [RAM_W-1:0] w_rd_word;

    logic                  r_out_valid;
    logic                  r_out_last;
    logic [AXI_KEEP_W-1:0] r_out_keep;
    logic [AXI_DATA_W-1:0] r_out_data;
    logic                  r_drop_pulse;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Full when write pointer is exactly DEPTH ahead of the read pointer:
    // same RAM address, opposite wrap bit.
    assign w_full = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    assign w_bad_frame = r_bad | udp_axis_tuser_i;
    assign w_wr_word   = {udp_axis_tlast_i, udp_axis_tkeep_i, udp_axis_tdata_i};

    sf_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_word)
    );

    // ---------------- ingress FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_bad        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_bad        <= w_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_bad_nxt    = r_bad;
        w_wr_en      = 1'b0;
        w_drop       = 1'b0;

        if (udp_axis_tvalid_i) begin
            if (r_state == S_DROP) begin
                if (udp_axis_tlast_i) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end else if (w_full) begin
                // Frame cannot fit: rewind to the last committed frame and
                // swallow the remainder.
                w_wr_ptr_nxt = r_commit_ptr;
                w_bad_nxt    = 1'b0;
                if (udp_axis_tlast_i) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                if (udp_axis_tlast_i) begin
                    w_state_nxt = S_IDLE;
                    w_bad_nxt   = 1'b0;
                    if (w_bad_frame) begin
                        w_drop       = 1'b1;
                        w_wr_ptr_nxt = r_commit_ptr;
                    end else begin
                        w_commit_nxt = r_wr_ptr + PTR_ONE;
                    end
                end else begin
                    w_bad_nxt   = w_bad_frame;
                    w_state_nxt = S_FRAME;
                end
            end
        end
    end

    // ---------------- drop reporting ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    // ---------------- egress output register ----------------
    // Only beats below commit_ptr are ever read, so the read address never
    // collides with the beat currently being written.
    assign w_load = (r_rd_ptr != r_commit_ptr) && (!r_out_valid || mold_axis_tready_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_keep  <= '0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            r_out_valid <= 1'b1;
            {r_out_last, r_out_keep, r_out_data} <= w_rd_word;
        end else if (mold_axis_tready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign udp_axis_tready_o  = ~reset;
    assign mold_axis_tvalid_o = r_out_valid;
    assign mold_axis_tkeep_o  = r_out_keep;
    assign mold_axis_tdata_o  = r_out_data;
    assign mold_axis_tlast_o  = r_out_last;
    assign mold_axis_tuser_o  = 1'b0;
    assign frame_drop_o       = r_drop_pulse;
    assign drop_cnt_o         = r_drop_cnt;

endmodule

// File: tb/tb_udp_sf_frame_fifo.sv
module tb_udp_sf_frame_fifo;

    localparam int unsigned DW    = 64;
    localparam int unsigned KW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          u_tvalid = 1'b0;
    logic [KW-1:0] u_tkeep = '0;
    logic [DW-1:0] u_tdata = '0;
    logic          u_tlast = 1'b0;
    logic          u_tuser = 1'b0;
    logic          u_tready;
    logic          m_tvalid;
    logic [KW-1:0] m_tkeep;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic          mold_tready = 1'b1;
    logic          frame_drop;
    logic [CW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int drop_pulses = 0;
    bit tog = 1'b0;
    bit prev_stall = 1'b0;
    logic [72:0] prev_word = '0;
    logic [72:0] rx_q[$];
    logic [72:0] exp_q[$];

    udp_sf_frame_fifo #(
        .AXI_DATA_W (DW),
        .AXI_KEEP_W (KW),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW),
        .DROP_CNT_W (CW)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .udp_axis_tvalid_i  (u_tvalid),
        .udp_axis_tkeep_i   (u_tkeep),
        .udp_axis_tdata_i   (u_tdata),
        .udp_axis_tlast_i   (u_tlast),
        .udp_axis_tuser_i   (u_tuser),
        .udp_axis_tready_o  (u_tready),
        .mold_axis_tvalid_o (m_tvalid),
        .mold_axis_tkeep_o  (m_tkeep),
        .mold_axis_tdata_o  (m_tdata),
        .mold_axis_tlast_o  (m_tlast),
        .mold_axis_tuser_o  (m_tuser),
        .mold_axis_tready_i (mold_tready),
        .frame_drop_o       (frame_drop),
        .drop_cnt_o         (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_data(input int id, input int b);
        logic [7:0] i8;
        logic [7:0] b8;
        i8 = id[7:0];
        b8 = b[7:0];
        return {i8, b8, 16'hC0DE, i8 ^ 8'h5A, b8, 16'h1234};
    endfunction

    function automatic logic [72:0] mk_word(input int id, input int b, input int len);
        logic l;
        l = (b == len - 1);
        return {l, (l ? 8'h3F : 8'hFF), mk_data(id, b)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs for the coming posedge are already set; the
    // egress handshake is recorded here, then time advances to negedge+1.
    task automatic cyc();
        logic [72:0] cur;
        if (tog) mold_tready = ~mold_tready;
        cur = {m_tlast, m_tkeep, m_tdata};
        if (prev_stall) begin
            chk("hold_valid", 128'(m_tvalid), 128'd1);
            chk("hold_beat", 128'(cur), 128'(prev_word));
        end
        if (frame_drop) drop_pulses++;
        if (m_tvalid && mold_tready) rx_q.push_back(cur);
        prev_stall = m_tvalid && !mold_tready;
        prev_word  = cur;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int id, input int len, input int bad_beat, input bit pass);
        for (int b = 0; b < len; b++) begin
            u_tvalid = 1'b1;
            u_tdata  = mk_data(id, b);
            u_tkeep  = (b == len - 1) ? 8'h3F : 8'hFF;
            u_tlast  = (b == len - 1);
            u_tuser  = (b == bad_beat);
            if (pass) exp_q.push_back(mk_word(id, b, len));
            cyc();
        end
        u_tvalid = 1'b0;
        u_tlast  = 1'b0;
        u_tuser  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (rx_q.size() < exp_q.size() && k < 200) begin
            cyc();
            k++;
        end
        repeat (4) cyc();
        chk({tag, "_count"}, 128'(rx_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_beat"}, 128'(rx_q[i]), 128'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        @(negedge clk);
        #1;
        // reset state
        chk("rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_tready", 128'(u_tready), 128'd0);
        chk("rst_drop", 128'(frame_drop), 128'd0);
        chk("rst_cnt", 128'(drop_cnt), 128'd0);
        chk("rst_data", 128'({m_tlast, m_tkeep, m_tdata}), 128'd0);
        reset = 1'b0;
        #1;
        chk("run_tready", 128'(u_tready), 128'd1);
        cyc();
        cyc();

        // clean 3-beat frame, latency from tlast
        send(1, 3, -1, 1'b1);
        chk("t1_lat_n", 128'(m_tvalid), 128'd0);
        cyc();
        chk("t1_lat_n1", 128'(m_tvalid), 128'd1);
        chk("t1_first", 128'({m_tlast, m_tkeep, m_tdata}), 128'(mk_word(1, 0, 3)));
        chk("t1_tuser", 128'(m_tuser), 128'd0);
        drain("t1");

        // error on a middle beat, then error on the last beat only
        drop_pulses = 0;
        send(2, 4, 1, 1'b0);
        send(3, 2, 1, 1'b0);
        repeat (3) cyc();
        chk("t2_pulses", 128'(drop_pulses), 128'd2);
        chk("t2_cnt", 128'(drop_cnt), 128'd2);
        drain("t2");

        // stalled egress: second 5-beat frame overflows and is dropped
        mold_tready = 1'b0;
        drop_pulses = 0;
        send(4, 5, -1, 1'b1);
        send(5, 5, -1, 1'b0);
        repeat (3) cyc();
        chk("t3_pulses", 128'(drop_pulses), 128'd1);
        chk("t3_cnt", 128'(drop_cnt), 128'd3);
        chk("t3_held", 128'(m_tvalid), 128'd1);
        mold_tready = 1'b1;
        drain("t3");

        // back-to-back single-beat frames with toggling ready
        tog = 1'b1;
        for (int i = 0; i < 8; i++) send(10 + i, 1, -1, 1'b1);
        drain("t4");
        tog = 1'b0;
        mold_tready = 1'b1;

        // frame longer than the buffer drops, next frame still passes
        drop_pulses = 0;
        send(20, 10, -1, 1'b0);
        repeat (3) cyc();
        chk("t5_pulses", 128'(drop_pulses), 128'd1);
        chk("t5_cnt", 128'(drop_cnt), 128'd4);
        drain("t5");
        send(21, 2, -1, 1'b1);
        drain("t5b");

        // reset in the middle of egress
        send(22, 6, -1, 1'b0);
        cyc();
        cyc();
        chk("t6_busy", 128'(m_tvalid), 128'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 128'(m_tvalid), 128'd0);
        chk("t6_async_data", 128'({m_tlast, m_tkeep, m_tdata}), 128'd0);
        chk("t6_async_cnt", 128'(drop_cnt), 128'd0);
        chk("t6_async_tready", 128'(u_tready), 128'd0);
        cyc();
        cyc();
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        drain("t6_lost");

        // fresh pointers: 6 beats at 0..5, then 6 beats straddling the RAM end,
        // then 5 beats crossing the pointer wrap bit
        send(23, 6, -1, 1'b1);
        drain("t7");
        send(24, 6, -1, 1'b1);
        drain("t7_wrap");
        send(25, 5, -1, 1'b1);
        drain("t7_ptrwrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
